ex_muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide engine for the EX stage. It replaces the single-purpose divider handshake with one unit that executes signed and unsigned multiply, multiply-accumulate/subtract and divide, generalised to WIDTH bits. The unit drives its own stall request, can be flushed by exceptions, and returns a HI/LO pair for the HI/LO write path.

---
 rtl/ex_muldiv_unit.sv | 188 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply / multiply-accumulate / divide engine.
// Drives its own stall request and returns a registered HI/LO pair.
module ex_muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             cancel,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH + MUL_STAGES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic               in_div, in_sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               mul_sgn;
    logic [2*WIDTH-1:0] sa, sb, prod, mres;
    logic [WIDTH:0]     rem_sh;
    logic               ge;
    logic [WIDTH-1:0]   rem_n, quot_n;

    always_comb begin
        in_div = !op[2] && op[1];
        in_sgn = !op[0];
        mag_a  = (in_sgn && opa[WIDTH-1]) ? -opa : opa;
        mag_b  = (in_sgn && opb[WIDTH-1]) ? -opb : opb;
    end

    always_comb begin
        mul_sgn = !op_q[0];
        sa      = {{WIDTH{mul_sgn & a_q[WIDTH-1]}}, a_q};
        sb      = {{WIDTH{mul_sgn & b_q[WIDTH-1]}}, b_q};
        prod    = sa * sb;
        if (op_q[2]) begin
            mres = op_q[1] ? (acc_q - prod) : (acc_q + prod);
        end else begin
            mres = prod;
        end
    end

    // a_q doubles as the quotient shift register, b_q as the divisor.
    always_comb begin
        rem_sh = {rem_q, a_q[WIDTH-1]};
        ge     = rem_sh >= {1'b0, b_q};
        rem_n  = ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
        quot_n = {a_q[WIDTH-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    acc_d  = {hi_i, lo_i};
                    a_d    = in_div ? mag_a : opa;
                    b_d    = in_div ? mag_b : opb;
                    rem_d  = '0;
                    qneg_d = in_div && in_sgn && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    rneg_d = in_div && in_sgn && opa[WIDTH-1];
                    if (!in_div) begin
                        state_d = S_MUL;
                        cnt_d   = CW'(MUL_STAGES);
                    end else if (opb == '0) begin
                        state_d = S_DONE;
                        hi_d    = opa;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = CW'(WIDTH);
                    end
                end
            end
            S_MUL: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d      = S_DONE;
                    {hi_d, lo_d} = mres;
                end
            end
            S_DIV: begin
                cnt_d = cnt_q - CW'(1);
                rem_d = rem_n;
                a_d   = quot_n;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    hi_d    = rneg_q ? -rem_n : rem_n;
                    lo_d    = qneg_q ? -quot_n : quot_n;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                dbz_d   = 1'b0;
            end
        endcase
        // A flush discards the in-flight op and any pending result.
        if (cancel) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        stall_o = ((state_q == S_IDLE) && start && !cancel)
                || (state_q == S_MUL) || (state_q == S_DIV);
        valid_o       = (state_q == S_DONE) && !cancel;
        div_by_zero_o = dbz_q && valid_o;
        hi_o          = hi_q;
        lo_o          = lo_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, results, cancel and reset.
// Inputs change just after negedge; outputs are sampled 1ns later.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic [31:0] hi_i = '0;
    logic [31:0] lo_i = '0;
    logic        cancel = 1'b0;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_by_zero_o;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MADD  = 3'b100;
    localparam logic [2:0] MSUB  = 3'b110;
    localparam logic [2:0] MSUBU = 3'b111;

    ex_muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .opa          (opa),
        .opb          (opb),
        .hi_i         (hi_i),
        .lo_i         (lo_i),
        .cancel       (cancel),
        .stall_o      (stall_o),
        .valid_o      (valid_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Start one op, scramble the operand inputs afterwards, and check the
    // stall/valid profile up to the result cycle.
    task automatic run(input string tag, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input int lat, input logic [31:0] eh,
                       input logic [31:0] el, input logic ed,
                       input bit hold);
        tick();
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        hi_i  = hi;
        lo_i  = lo;
        #1;
        chk({tag, " c0 stall"}, 32'(stall_o), 32'd1);
        for (int k = 1; k < lat; k++) begin
            tick();
            start = hold;
            op    = ~o;
            opa   = ~a;
            opb   = ~b;
            hi_i  = ~hi;
            lo_i  = ~lo;
            #1;
            chk($sformatf("%s c%0d valid", tag, k), 32'(valid_o), 32'd0);
            chk($sformatf("%s c%0d stall", tag, k), 32'(stall_o), 32'd1);
        end
        tick();
        start = 1'b0;
        op    = ~o;
        opa   = ~a;
        opb   = ~b;
        #1;
        chk({tag, " done valid"}, 32'(valid_o), 32'd1);
        chk({tag, " done stall"}, 32'(stall_o), 32'd0);
        chk({tag, " hi"}, hi_o, eh);
        chk({tag, " lo"}, lo_o, el);
        chk({tag, " dbz"}, 32'(div_by_zero_o), 32'(ed));
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        #1;
        chk("reset hi", hi_o, 32'h0);
        chk("reset lo", lo_o, 32'h0);
        chk("reset valid", 32'(valid_o), 32'd0);
        chk("reset stall", 32'(stall_o), 32'd0);
        chk("reset dbz", 32'(div_by_zero_o), 32'd0);
        rst = 1'b0;

        run("mult", MULT, 32'hFFFFFFFF, 32'h2, 0, 0, 3,
            32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
        tick();
        #1;
        chk("hold valid", 32'(valid_o), 32'd0);
        chk("hold hi", hi_o, 32'hFFFFFFFF);
        chk("hold lo", lo_o, 32'hFFFFFFFE);

        run("multu", MULTU, 32'hFFFFFFFF, 32'h2, 0, 0, 3,
            32'h1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run("div_m7_2", DIV, 32'hFFFFFFF9, 32'h2, 0, 0, 33,
            32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run("divu_100_7", DIVU, 32'd100, 32'd7, 0, 0, 33,
            32'd2, 32'd14, 1'b0, 1'b1);
        run("divu_by0", DIVU, 32'd7, 32'd0, 0, 0, 1,
            32'd7, 32'hFFFFFFFF, 1'b1, 1'b0);
        run("div_by0", DIV, 32'hFFFFFFFB, 32'd0, 0, 0, 1,
            32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1'b0);
        run("madd", MADD, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 3,
            32'h1, 32'h0, 1'b0, 1'b0);
        run("msub", MSUB, 32'd1, 32'd1, 32'h0, 32'h0, 3,
            32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        run("msubu", MSUBU, 32'd3, 32'd5, 32'h0, 32'd10, 3,
            32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b0);
        run("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, 33,
            32'h0, 32'h80000000, 1'b0, 1'b0);
        run("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE, 0, 0, 33,
            32'h1, 32'hFFFFFFFD, 1'b0, 1'b0);
        run("div_m8_3", DIV, 32'hFFFFFFF8, 32'd3, 0, 0, 33,
            32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b0);
        run("mult_min2", MULT, 32'h80000000, 32'h80000000, 0, 0, 3,
            32'h40000000, 32'h0, 1'b0, 1'b0);

        // cancel together with start in IDLE: nothing starts
        tick();
        start  = 1'b1;
        cancel = 1'b1;
        op     = MULTU;
        opa    = 32'd9;
        opb    = 32'd9;
        #1;
        chk("cancel_start stall", 32'(stall_o), 32'd0);
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        #1;
        chk("cancel_start idle stall", 32'(stall_o), 32'd0);
        chk("cancel_start valid", 32'(valid_o), 32'd0);
        chk("cancel_start lo", lo_o, 32'h0);

        // DIV cancelled at cycle 10, MULTU 3x5 started at cycle 11
        tick();
        start = 1'b1;
        op    = DIVU;
        opa   = 32'd100;
        opb   = 32'd7;
        #1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            start  = 1'b0;
            cancel = (k == 10);
            #1;
            chk($sformatf("cancel c%0d valid", k), 32'(valid_o), 32'd0);
        end
        tick();
        cancel = 1'b0;
        #1;
        chk("cancel c11 stall", 32'(stall_o), 32'd0);
        chk("cancel c11 valid", 32'(valid_o), 32'd0);
        chk("cancel c11 hi", hi_o, 32'h40000000);
        chk("cancel c11 lo", lo_o, 32'h0);
        start = 1'b1;
        op    = MULTU;
        opa   = 32'd3;
        opb   = 32'd5;
        #1;
        chk("restart c11 stall", 32'(stall_o), 32'd1);
        tick();
        start = 1'b0;
        #1;
        chk("restart c12 valid", 32'(valid_o), 32'd0);
        tick();
        #1;
        chk("restart c13 stall", 32'(stall_o), 32'd1);
        tick();
        #1;
        chk("restart c14 valid", 32'(valid_o), 32'd1);
        chk("restart c14 lo", lo_o, 32'd15);
        chk("restart c14 hi", hi_o, 32'd0);

        // reset in the middle of a divide
        tick();
        start = 1'b1;
        op    = DIVU;
        opa   = 32'd100;
        opb   = 32'd7;
        for (int k = 1; k <= 5; k++) begin
            tick();
            start = 1'b0;
        end
        rst   = 1'b1;
        start = 1'b1;
        tick();
        #1;
        chk("rst hi", hi_o, 32'h0);
        chk("rst lo", lo_o, 32'h0);
        chk("rst valid", 32'(valid_o), 32'd0);
        chk("rst dbz", 32'(div_by_zero_o), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        #1;
        chk("rst stall", 32'(stall_o), 32'd0);
        tick();
        #1;
        chk("rst start ignored stall", 32'(stall_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
